cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Parametrised CP0 coprocessor register block for the pipelined MIPS core; successor to the single-register Status block.
- Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14), with mtc0/mfc0 access and a same-cycle write bypass.
- Adds exception entry/ERET sequencing, a prescaled Count/Compare timer and interrupt request generation.
- Sits beside the MEM/WB stage; exception and eret commands come from the exception unit.

Parameters:
- DATA_W, 32, register width; must be at least 16.
- STATUS_RST, 32'h0000FF01, Status reset value (IM=FF, IE=1, EXL=0).
- HW_IRQ, 6, number of external interrupt lines, 1..6, mapped to IP[2+HW_IRQ-1:2].
- COUNT_DIV, 2, clk cycles per Count increment, at least 1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  mtc0 write enable.
- waddr  in  5  mtc0 register number.
- wdata  in  DATA_W  mtc0 data.
- raddr  in  5  mfc0 register number.
- rdata  out  DATA_W  mfc0 data, combinational.
- exc_valid  in  1  take exception this cycle.
- exc_code  in  5  ExcCode to record.
- exc_pc  in  DATA_W  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a delay slot.
- exc_badvaddr  in  DATA_W  faulting address.
- eret  in  1  eret commits this cycle.
- hw_irq  in  HW_IRQ  level-sensitive external interrupts.
- int_req  out  1  interrupt request to the exception unit.
- status_out  out  DATA_W  current Status.
- epc_out  out  DATA_W  current EPC.

Behaviour:
- Reset values: Status=STATUS_RST; Cause, EPC, Count, Compare, BadVAddr, prescaler = 0. Consequently int_req=0, epc_out=0, status_out=STATUS_RST.
- Update priority per cycle: rst, then exc_valid, then eret, then we. A lower-priority write in the same cycle is dropped entirely.
- Status writable bits: IE[0], EXL[1], IM[15:8]. Other bits hold their reset value.
- Cause write: only IP[9:8] are writable (software interrupts).
- Cause IP[7:2]: hardware-driven, refreshed every cycle as hw_irq, zero-extended, with TI ORed into IP[7].
- Cause TI[30] is sticky. Cause BD[31] and ExcCode[6:2] are written only on exception entry.
- Count/Compare/EPC: fully writable.
- BadVAddr: read-only; a write to it is ignored.
- Unimplemented registers: read 0; writes are ignored.
- Read bypass: if we=1, waddr==raddr, the register is writable, and no exc_valid/eret is active, rdata = the masked post-write value. Otherwise rdata = the registered value.
- Exception entry (exc_valid=1), with EXL=0:
  - EXL<=1; ExcCode<=exc_code; BD<=exc_bd.
  - EPC<=exc_bd ? exc_pc-4 : exc_pc.
- Exception entry with EXL already 1 (nested exception): EPC and BD are held; ExcCode is still updated.
- BadVAddr<=exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
- eret: EXL<=0 on the next edge; no other state changes.
- Timer prescaler:
  - Counts 0..COUNT_DIV-1. Count increments, wrapping FFFFFFFF->0, on the edge where the prescaler equals COUNT_DIV-1.
  - An mtc0 to Count loads wdata and clears the prescaler.
- Timer interrupt:
  - TI<=1 on the edge where Count's new value equals Compare.
  - An mtc0 to Compare clears TI. If a Compare write and a match occur in the same cycle, the clear wins.
- int_req = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]). It is combinational from registered state, so the earliest assertion is one cycle after the enabling event.
- Reset mid-operation overrides any pending exception, eret or write in that cycle.

Test Plan:
- Reset, then read regs 12/13/14 -> 0x0000FF01 / 0 / 0. Then mtc0 Status=0xFFFFFFFF -> read 0x0000FF03.
- exc_valid, exc_code=4, exc_pc=0x100, exc_bd=1, exc_badvaddr=0x33 -> EPC=0xFC, Cause=0x80000010, BadVAddr=0x33, EXL=1. A second exc with exc_pc=0x200 -> EPC stays 0xFC.
- eret and exc_valid in the same cycle -> EXL remains 1. A lone eret next cycle -> EXL=0, EPC unchanged.
- Compare=5, Count=0, COUNT_DIV=2 -> TI=1 and Cause[15]=1 after 10 cycles, int_req=1. Then mtc0 Compare -> TI=0, int_req=0.
- hw_irq[0]=1 with IM[10]=0 -> int_req=0. Set IM[10] -> int_req=1 next cycle. Then set EXL -> int_req=0.
- mtc0 Count=0xFFFFFFFF -> wraps to 0 after COUNT_DIV cycles. Same-cycle mtc0 EPC=0x40 with mfc0 EPC -> rdata=0x40.

Source files
------------

// File: rtl/cp0_regfile.sv
// CP0 register block: BadVAddr, Count, Compare, Status, Cause and EPC with
// mtc0/mfc0 access, exception/ERET sequencing, a prescaled timer and interrupt requests.
module cp0_regfile #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] STATUS_RST = 32'h0000FF01,
  parameter int unsigned HW_IRQ     = 6,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic              exc_bd,
  input  logic [DATA_W-1:0] exc_badvaddr,
  input  logic              eret,
  input  logic [HW_IRQ-1:0] hw_irq,
  output logic              int_req,
  output logic [DATA_W-1:0] status_out,
  output logic [DATA_W-1:0] epc_out
);

  localparam int unsigned WW = (DATA_W > 32) ? DATA_W : 32;
  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_STATUS   = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;

  logic              ie, exl;
  logic [7:0]        im;
  logic              bd, ti;
  logic [1:0]        ip_sw;
  logic [5:0]        ip_hw;
  logic [4:0]        exccode;
  logic [DATA_W-1:0] badvaddr, count, compare, epc;
  logic [PW-1:0]     presc;

  logic [5:0]        hw_ext;
  logic [7:0]        ip;
  logic [WW-1:0]     status_w, status_bp_w, cause_w, cause_bp_w;
  logic [DATA_W-1:0] status_val, cause_val;
  logic              wr_en, wr_count, wr_compare, tick, count_upd;
  logic [DATA_W-1:0] count_next;
  logic [PW-1:0]     presc_next;
  logic [DATA_W-1:0] reg_val, bp_val;
  logic              bp_hit;

  always_comb begin
    hw_ext = '0;
    hw_ext[HW_IRQ-1:0] = hw_irq;
  end

  assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};

  // Registers are assembled at 32 bits minimum so field positions stay fixed for any DATA_W.
  always_comb begin
    status_w          = WW'(STATUS_RST);
    status_w[0]       = ie;
    status_w[1]       = exl;
    status_w[15:8]    = im;
    status_bp_w       = WW'(STATUS_RST);
    status_bp_w[1:0]  = wdata[1:0];
    status_bp_w[15:8] = wdata[15:8];
    cause_w           = '0;
    cause_w[31]       = bd;
    cause_w[30]       = ti;
    cause_w[15:8]     = ip;
    cause_w[6:2]      = exccode;
    cause_bp_w        = cause_w;
    cause_bp_w[9:8]   = wdata[9:8];
  end

  assign status_val = status_w[DATA_W-1:0];
  assign cause_val  = cause_w[DATA_W-1:0];
  assign status_out = status_val;
  assign epc_out    = epc;

  assign wr_en      = we & ~exc_valid & ~eret;
  assign wr_count   = wr_en && (waddr == R_COUNT);
  assign wr_compare = wr_en && (waddr == R_COMPARE);
  assign tick       = (presc == PW'(COUNT_DIV - 1));
  assign count_upd  = wr_count | tick;

  always_comb begin
    count_next = count;
    presc_next = tick ? '0 : presc + PW'(1);
    if (wr_count) begin
      count_next = wdata;
      presc_next = '0;
    end else if (tick) begin
      count_next = count + DATA_W'(1);
    end
  end

  assign int_req = ie & ~exl & |(ip & im);

  always_comb begin
    reg_val = '0;
    case (raddr)
      R_BADVADDR: reg_val = badvaddr;
      R_COUNT:    reg_val = count;
      R_COMPARE:  reg_val = compare;
      R_STATUS:   reg_val = status_val;
      R_CAUSE:    reg_val = cause_val;
      R_EPC:      reg_val = epc;
      default:    reg_val = '0;
    endcase
  end

  always_comb begin
    bp_val = '0;
    bp_hit = 1'b0;
    case (waddr)
      R_COUNT:   begin bp_val = wdata;                        bp_hit = 1'b1; end
      R_COMPARE: begin bp_val = wdata;                        bp_hit = 1'b1; end
      R_STATUS:  begin bp_val = status_bp_w[DATA_W-1:0];      bp_hit = 1'b1; end
      R_CAUSE:   begin bp_val = cause_bp_w[DATA_W-1:0];       bp_hit = 1'b1; end
      R_EPC:     begin bp_val = wdata;                        bp_hit = 1'b1; end
      default:   begin bp_val = '0;                           bp_hit = 1'b0; end
    endcase
  end

  assign rdata = (wr_en && bp_hit && (waddr == raddr)) ? bp_val : reg_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      ie       <= STATUS_RST[0];
      exl      <= STATUS_RST[1];
      im       <= STATUS_RST[15:8];
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip_sw    <= '0;
      ip_hw    <= '0;
      exccode  <= '0;
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      presc    <= '0;
    end else begin
      ip_hw <= hw_ext;
      count <= count_next;
      presc <= presc_next;
      if (wr_compare)
        ti <= 1'b0;
      else if (count_upd && (count_next == compare))
        ti <= 1'b1;

      if (exc_valid) begin
        exl     <= 1'b1;
        exccode <= exc_code;
        if (!exl) begin
          bd  <= exc_bd;
          epc <= exc_bd ? exc_pc - DATA_W'(4) : exc_pc;
        end
        if (exc_code == 5'd4 || exc_code == 5'd5)
          badvaddr <= exc_badvaddr;
      end else if (eret) begin
        exl <= 1'b0;
      end else if (we) begin
        case (waddr)
          R_COMPARE: compare <= wdata;
          R_STATUS: begin
            ie  <= wdata[0];
            exl <= wdata[1];
            im  <= wdata[15:8];
          end
          R_CAUSE:   ip_sw <= wdata[9:8];
          R_EPC:     epc   <= wdata;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: table of mtc0/mfc0 vectors plus hand-written
// sequences for exceptions, ERET, timer, interrupts, bypass and reset.
module tb_cp0_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_irq;
  logic        int_req;
  logic [31:0] status_out;
  logic [31:0] epc_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cp0_regfile #(
    .DATA_W(32),
    .STATUS_RST(32'h0000FF01),
    .HW_IRQ(6),
    .COUNT_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata),
    .exc_valid(exc_valid),
    .exc_code(exc_code),
    .exc_pc(exc_pc),
    .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr),
    .eret(eret),
    .hw_irq(hw_irq),
    .int_req(int_req),
    .status_out(status_out),
    .epc_out(epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd12, 32'h0000FF01, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd13, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd14, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 5'd12, 32'h0000FF03, 1'b0};
    vecs[4]  = '{1'b1, 5'd12, 32'h0000FF01, 5'd12, 32'h0000FF01, 1'b0};
    vecs[5]  = '{1'b1, 5'd14, 32'hDEADBEEF, 5'd14, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 5'd13, 32'h00000300, 1'b1};
    vecs[7]  = '{1'b1, 5'd13, 32'h00000000, 5'd13, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 5'd8,  32'h00001234, 5'd8,  32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 5'd20, 32'h00000005, 5'd20, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 5'd11, 32'h00001000, 5'd11, 32'h00001000, 1'b0};
    vecs[11] = '{1'b1, 5'd14, 32'h00000000, 5'd14, 32'h00000000, 1'b0};

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr = '0; eret = 1'b0; hw_irq = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_status_out", status_out, 32'h0000FF01);
    check("reset_epc_out", epc_out, 32'h0);
    check("reset_int_req", {31'b0, int_req}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      we    = vecs[i].we;
      waddr = vecs[i].waddr;
      wdata = vecs[i].wdata;
      raddr = vecs[i].raddr;
      step();
      we = 1'b0;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      check($sformatf("vec%0d_int_req", i), {31'b0, int_req}, {31'b0, vecs[i].exp_irq});
    end

    // Exception entry in a delay slot with an address error
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h100; exc_bd = 1'b1; exc_badvaddr = 32'h33;
    step();
    exc_valid = 1'b0;
    check("exc_epc", epc_out, 32'h000000FC);
    check("exc_status_exl", status_out, 32'h0000FF03);
    rd(5'd13, "exc_cause", 32'h80000010);
    rd(5'd8, "exc_badvaddr", 32'h00000033);
    check("exc_int_req", {31'b0, int_req}, 32'h0);

    // Nested exception: EPC/BD held, ExcCode updated, BadVAddr untouched
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h200; exc_bd = 1'b0; exc_badvaddr = 32'h77;
    step();
    exc_valid = 1'b0;
    check("nested_epc", epc_out, 32'h000000FC);
    rd(5'd13, "nested_cause", 32'h80000030);
    rd(5'd8, "nested_badvaddr", 32'h00000033);

    // eret together with exception: exception wins
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h300; eret = 1'b1;
    step();
    exc_valid = 1'b0; eret = 1'b0;
    check("eret_exc_status", status_out, 32'h0000FF03);
    check("eret_exc_epc", epc_out, 32'h000000FC);

    // Lone eret with a simultaneous mtc0 EPC: write dropped, no bypass
    eret = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'h55; raddr = 5'd14;
    #1;
    check("eret_no_bypass", rdata, 32'h000000FC);
    step();
    eret = 1'b0; we = 1'b0;
    check("eret_status", status_out, 32'h0000FF01);
    check("eret_epc", epc_out, 32'h000000FC);

    // Timer: Compare=5, Count=0, two clocks per Count tick
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    repeat (9) step();
    rd(5'd13, "timer_before_cause", 32'h80000000);
    check("timer_before_int_req", {31'b0, int_req}, 32'h0);
    step();
    rd(5'd13, "timer_hit_cause", 32'hC0008000);
    rd(5'd9, "timer_hit_count", 32'd5);
    check("timer_hit_int_req", {31'b0, int_req}, 32'h1);
    wr(5'd11, 32'h00001000);
    rd(5'd13, "timer_clear_cause", 32'h80000000);
    check("timer_clear_int_req", {31'b0, int_req}, 32'h0);

    // External interrupt masking
    hw_irq = 6'b000001;
    wr(5'd12, 32'h0000FB01);
    step();
    check("hwirq_masked", {31'b0, int_req}, 32'h0);
    rd(5'd13, "hwirq_cause", 32'h80000400);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000FF01;
    #1;
    check("hwirq_pre_edge", {31'b0, int_req}, 32'h0);
    step();
    we = 1'b0;
    check("hwirq_enabled", {31'b0, int_req}, 32'h1);
    wr(5'd12, 32'h0000FF03);
    check("hwirq_exl_blocks", {31'b0, int_req}, 32'h0);
    hw_irq = 6'b000000;
    wr(5'd12, 32'h0000FF01);
    step();
    check("hwirq_released", {31'b0, int_req}, 32'h0);

    // Count wrap
    wr(5'd9, 32'hFFFFFFFF);
    rd(5'd9, "wrap_loaded", 32'hFFFFFFFF);
    step();
    rd(5'd9, "wrap_hold", 32'hFFFFFFFF);
    step();
    rd(5'd9, "wrap_zero", 32'h00000000);

    // Same-cycle write/read bypass
    we = 1'b1; waddr = 5'd14; wdata = 32'h40; raddr = 5'd14;
    #1;
    check("bypass_epc", rdata, 32'h00000040);
    step();
    check("bypass_epc_stored", epc_out, 32'h00000040);
    waddr = 5'd12; wdata = 32'hFFFFFFFF; raddr = 5'd12;
    #1;
    check("bypass_status_mask", rdata, 32'h0000FF03);
    wdata = 32'h0000FF01;
    #1;
    check("bypass_status", rdata, 32'h0000FF01);
    step();
    waddr = 5'd8; wdata = 32'h99; raddr = 5'd8;
    #1;
    check("bypass_badvaddr_ro", rdata, 32'h00000033);
    step();
    we = 1'b0;
    rd(5'd8, "badvaddr_ro", 32'h00000033);

    // Reset overrides exception and write in the same cycle
    we = 1'b1; waddr = 5'd14; wdata = 32'h77; raddr = 5'd14;
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h500; exc_bd = 1'b0; exc_badvaddr = 32'h88;
    #1;
    check("exc_blocks_bypass", rdata, 32'h00000040);
    rst = 1'b1;
    step();
    rst = 1'b0; we = 1'b0; exc_valid = 1'b0;
    check("midrst_epc", epc_out, 32'h0);
    check("midrst_status", status_out, 32'h0000FF01);
    rd(5'd13, "midrst_cause", 32'h0);
    rd(5'd8, "midrst_badvaddr", 32'h0);
    check("midrst_int_req", {31'b0, int_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
